// File: rtl/pe_nic_if.sv
// Bus bundle between the NIC and its two neighbours: the processor register
// port and the router PE port. The NIC takes the slave side; the processor
// and router models (or the bench) take the master side.
interface pe_nic_if #(
  parameter int DATA_WIDTH = 64
);
  // processor register port
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  // router PE port, NIC -> router
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  // router PE port, router -> NIC
  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;
  logic                  net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    input  net_ro, net_si, net_di, net_polarity,
    output d_out, net_so, net_do, net_ri
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    output net_ro, net_si, net_di, net_polarity,
    input  d_out, net_so, net_do, net_ri
  );
endinterface

// File: rtl/pe_nic.sv
// Network interface between a processing element and a mesh router PE port.
// One single-entry buffer per direction, each with a full flag, exposed to
// the processor through a 4-register memory map. Packets pass through
// unmodified; the VC bit (MSB) gates transmission against router polarity.
module pe_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  pe_nic_if.slave  bus
);

  localparam logic [1:0] A_IN_BUF  = 2'b00;
  localparam logic [1:0] A_IN_ST   = 2'b01;
  localparam logic [1:0] A_OUT_BUF = 2'b10;
  localparam logic [1:0] A_OUT_ST  = 2'b11;
  localparam int         VC_BIT    = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] in_buf;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] out_buf;
  logic                  out_full;

  logic rd_en;
  logic wr_en;
  logic out_wr;
  logic in_drain;
  logic send;
  logic accept;

  // Access decode and handshake strobes; all purely from registered state
  // plus current inputs, so the router sees no same-cycle buffer bypass.
  always_comb begin
    rd_en    = bus.nicEn & ~bus.nicWrEn;
    wr_en    = bus.nicEn &  bus.nicWrEn;
    out_wr   = wr_en & (bus.addr == A_OUT_BUF) & ~out_full;
    in_drain = rd_en & (bus.addr == A_IN_BUF) & in_full;
    send     = out_full & bus.net_ro & (bus.net_polarity == out_buf[VC_BIT]);
    accept   = bus.net_si & ~in_full;
  end

  assign bus.net_so = send;
  assign bus.net_do = out_buf;
  assign bus.net_ri = ~in_full;

  // Register read mux; d_out is forced to zero whenever no read is active.
  always_comb begin
    bus.d_out = '0;
    if (rd_en) begin
      unique case (bus.addr)
        A_IN_BUF:  bus.d_out = in_buf;
        A_IN_ST:   bus.d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
        A_OUT_BUF: bus.d_out = out_buf;
        A_OUT_ST:  bus.d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:   bus.d_out = '0;
      endcase
    end
  end

  // Transmit channel: processor fills, router drains on a matching-polarity
  // strobe. A write in the send cycle sees out_full=1 and is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (send) begin
      out_full <= 1'b0;
    end else if (out_wr) begin
      out_buf  <= bus.d_in;
      out_full <= 1'b1;
    end
  end

  // Receive channel: router fills only while empty, processor drains by
  // reading the buffer. The data stays readable after the drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (accept) begin
      in_buf  <= bus.net_di;
      in_full <= 1'b1;
    end else if (in_drain) begin
      in_full <= 1'b0;
    end
  end

  // Handshake sanity properties (checked in simulation only).
  a_send_gated: assert property (@(posedge clk) disable iff (reset)
    bus.net_so |-> (bus.net_ro && out_full))
    else $error("net_so without ready or buffered packet");
  a_send_clears: assert property (@(posedge clk) disable iff (reset)
    bus.net_so |=> !out_full)
    else $error("out_full not cleared after send");
  a_accept_fills: assert property (@(posedge clk) disable iff (reset)
    (bus.net_si && bus.net_ri) |=> in_full)
    else $error("in_full not set after delivery");

endmodule

// File: tb/tb_pe_nic.sv
// Self-checking bench for pe_nic: table-driven transmit and receive vectors
// plus hand sequences for reset, mid-transfer reset and concurrent traffic.
// Sent and delivered packets are tracked in scoreboard queues.
module tb_pe_nic;

  localparam int DW = 64;

  logic clk;
  logic reset;
  pe_nic_if #(.DATA_WIDTH(DW)) bus ();

  pe_nic #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] d;
  logic [DW-1:0] exp_v;

  typedef struct {
    logic [DW-1:0] pkt;
    int            ro_low;
    logic [DW-1:0] second_wr;
    logic [DW-1:0] exp_st_before;
    logic [DW-1:0] exp_hold_rd;
    logic [DW-1:0] exp_st_after;
  } tx_vec_t;

  typedef struct {
    logic [DW-1:0] di;
    logic [DW-1:0] junk;
    logic [DW-1:0] exp_st_full;
    logic [DW-1:0] exp_rd;
  } rx_vec_t;

  tx_vec_t txv[4];
  rx_vec_t rxv[3];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // router polarity flips every cycle, just after the rising edge
  initial begin
    bus.net_polarity = 0;
    forever begin
      @(posedge clk);
      #1 bus.net_polarity = ~bus.net_polarity;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [DW-1:0] v);
    bus.nicEn = 1; bus.nicWrEn = 0; bus.addr = a;
    #2 v = bus.d_out;
    cyc();
    bus.nicEn = 0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [DW-1:0] v);
    bus.nicEn = 1; bus.nicWrEn = 1; bus.addr = a; bus.d_in = v;
    cyc();
    bus.nicEn = 0; bus.nicWrEn = 0;
  endtask

  task automatic wait_tx(input string name);
    for (int k = 0; k < 4 && tx_q.size() != 0; k++) cyc();
    check(name, 64'(tx_q.size()), 64'd0);
  endtask

  // transmit monitor: every strobe must be legal and match the next packet
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.net_so) begin
        checks++;
        if (!bus.net_ro || bus.net_polarity !== bus.net_do[DW-1]) begin
          errors++;
          $display("FAIL tx_gate: net_ro=%0b polarity=%0b vc=%0b", bus.net_ro, bus.net_polarity, bus.net_do[DW-1]);
        end
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %h expected no send", bus.net_do);
        end else begin
          exp_v = tx_q.pop_front();
          if (bus.net_do !== exp_v) begin
            errors++;
            $display("FAIL tx_data: got %h expected %h", bus.net_do, exp_v);
          end
        end
      end
    end
  end

  initial begin
    txv[0] = '{64'h9010_0000_1111_1111, 0, 64'h0, 64'd1, 64'h9010_0000_1111_1111, 64'd0};
    txv[1] = '{64'h1010_0000_2222_2222, 5, 64'h5555_5555_5555_5555, 64'd1, 64'h1010_0000_2222_2222, 64'd0};
    txv[2] = '{64'h8123_4567_89AB_CDEF, 2, 64'h0BAD_0BAD_0BAD_0BAD, 64'd1, 64'h8123_4567_89AB_CDEF, 64'd0};
    txv[3] = '{64'h0000_0000_0000_0000, 0, 64'h0, 64'd1, 64'h0, 64'd0};
    rxv[0] = '{64'hC000_0000_0000_ABCD, 64'h0000_0000_0000_DEAD, 64'd1, 64'hC000_0000_0000_ABCD};
    rxv[1] = '{64'h4033_0007_1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h4033_0007_1234_5678};
    rxv[2] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 64'd1, 64'h0000_0000_0000_0001};

    bus.addr = 0; bus.d_in = 0; bus.nicEn = 1; bus.nicWrEn = 0;
    bus.net_ro = 0; bus.net_si = 1; bus.net_di = 64'hFFFF_0000_FFFF_0000;
    reset = 1;

    // reset with router strobing and processor enabled
    cyc(); cyc();
    reset = 0; bus.net_si = 0; bus.nicEn = 0;
    #1;
    check("rst_net_so", 64'(bus.net_so), 64'd0);
    check("rst_net_ri", 64'(bus.net_ri), 64'd1);
    check("rst_net_do", bus.net_do, 64'd0);
    check("rst_d_out", bus.d_out, 64'd0);
    cyc();
    reg_rd(2'b01, d); check("rst_in_st", d, 64'd0);
    reg_rd(2'b11, d); check("rst_out_st", d, 64'd0);

    // transmit vectors: polarity gating, backpressure, ignored re-write
    for (int i = 0; i < 4; i++) begin
      bus.net_ro = (txv[i].ro_low == 0);
      reg_wr(2'b10, txv[i].pkt);
      tx_q.push_back(txv[i].pkt);
      check($sformatf("tx%0d_do", i), bus.net_do, txv[i].pkt);
      reg_rd(2'b11, d); check($sformatf("tx%0d_st_before", i), d, txv[i].exp_st_before);
      if (txv[i].ro_low > 0) begin
        for (int k = 0; k < txv[i].ro_low; k++) begin
          #1 check($sformatf("tx%0d_hold_so", i), 64'(bus.net_so), 64'd0);
          cyc();
        end
        reg_wr(2'b10, txv[i].second_wr);
        reg_rd(2'b10, d); check($sformatf("tx%0d_hold_rd", i), d, txv[i].exp_hold_rd);
        bus.net_ro = 1;
      end
      wait_tx($sformatf("tx%0d_sent", i));
      reg_rd(2'b11, d); check($sformatf("tx%0d_st_after", i), d, txv[i].exp_st_after);
    end

    // receive vectors: fill, blocked delivery, drain, stale read
    for (int i = 0; i < 3; i++) begin
      bus.net_si = 1; bus.net_di = rxv[i].di;
      rx_q.push_back(rxv[i].exp_rd);
      cyc();
      bus.net_si = 0;
      #1 check($sformatf("rx%0d_ri_low", i), 64'(bus.net_ri), 64'd0);
      reg_rd(2'b01, d); check($sformatf("rx%0d_st", i), d, rxv[i].exp_st_full);
      bus.net_si = 1; bus.net_di = rxv[i].junk;
      cyc();
      bus.net_si = 0;
      reg_rd(2'b00, d);
      if (rx_q.size() == 0) check($sformatf("rx%0d_q", i), 64'd1, 64'd0);
      else check($sformatf("rx%0d_rd", i), d, rx_q.pop_front());
      #1 check($sformatf("rx%0d_ri_high", i), 64'(bus.net_ri), 64'd1);
      reg_rd(2'b00, d); check($sformatf("rx%0d_stale", i), d, rxv[i].exp_rd);
      reg_rd(2'b01, d); check($sformatf("rx%0d_st_empty", i), d, 64'd0);
    end

    // concurrent send and receive in the same cycle
    bus.net_ro = 0;
    reg_wr(2'b10, 64'h8000_0000_0000_0077);
    tx_q.push_back(64'h8000_0000_0000_0077);
    bus.net_ro = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.net_so) begin
        bus.net_si = 1; bus.net_di = 64'h2000_0000_0000_0099;
        rx_q.push_back(64'h2000_0000_0000_0099);
        break;
      end
      cyc();
    end
    check("conc_rx_driven", 64'(rx_q.size()), 64'd1);
    cyc();
    bus.net_si = 0;
    check("conc_tx_done", 64'(tx_q.size()), 64'd0);
    reg_rd(2'b11, d); check("conc_out_st", d, 64'd0);
    reg_rd(2'b01, d); check("conc_in_st", d, 64'd1);
    reg_rd(2'b00, d);
    if (rx_q.size() == 0) check("conc_q", 64'd1, 64'd0);
    else check("conc_rd", d, rx_q.pop_front());

    // reset mid-transfer: both buffers discarded, no send afterwards
    bus.net_ro = 0;
    reg_wr(2'b10, 64'h8000_0000_0000_0ABC);
    bus.net_si = 1; bus.net_di = 64'h0000_0000_0000_1234;
    cyc();
    bus.net_si = 0;
    reset = 1;
    cyc();
    reset = 0;
    bus.net_ro = 1;
    for (int k = 0; k < 4; k++) begin
      #1 check("mrst_no_send", 64'(bus.net_so), 64'd0);
      cyc();
    end
    check("mrst_net_ri", 64'(bus.net_ri), 64'd1);
    check("mrst_net_do", bus.net_do, 64'd0);
    reg_rd(2'b01, d); check("mrst_in_st", d, 64'd0);
    reg_rd(2'b11, d); check("mrst_out_st", d, 64'd0);
    reg_rd(2'b00, d); check("mrst_in_buf", d, 64'd0);

    // writes to non-writable addresses leave state alone
    reg_wr(2'b00, 64'hAAAA_AAAA_AAAA_AAAA);
    reg_wr(2'b11, 64'h1);
    reg_rd(2'b00, d); check("ro_in_buf", d, 64'd0);
    reg_rd(2'b11, d); check("ro_out_st", d, 64'd0);

    check("tx_q_empty", 64'(tx_q.size()), 64'd0);
    check("rx_q_empty", 64'(rx_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
